msk_bit_source: RTL and testbench
=================================

Name: msk_bit_source

Overview:
Parametrised serial bit source feeding msk_mod data_in. Accepts DATA_W-bit words over a valid/ready stream into an internal DEPTH-word buffer. Serialises each word at SPS clocks per bit, with continuous bit timing across word boundaries. Supports one-shot streaming and circular loop replay, plus clean stop, flush and underrun reporting.

Parameters:
DATA_W, 8, word width in bits (>=2)
DEPTH, 32, buffer depth in words (power of 2, >=2)
SPS, 20, clocks per bit (>=2)
MSB_FIRST, 1, 1 = serialise MSB first, 0 = LSB first

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
s_tdata  in  DATA_W  input word
s_tvalid  in  1  input word valid
s_tready  out  1  buffer can accept a word
start  in  1  begin transmission (honoured in IDLE only)
stop  in  1  finish the current word, then go IDLE
loop_en  in  1  loop mode, sampled on start
flush  in  1  empty the buffer (honoured in IDLE only)
bit_out  out  1  serial bit to the modulator
bit_val  out  1  one-cycle pulse on the first clock of each bit
busy  out  1  state != IDLE
underrun  out  1  one-cycle pulse on stream-mode starvation
level  out  $clog2(DEPTH+1)  words currently stored

Behaviour:
- Reset values: bit_out=0, bit_val=0, busy=0, underrun=0, level=0, pointers=0, s_tready=1, state=IDLE.
- Buffer:
  - Register array with combinational read.
  - Write fires on s_tvalid&&s_tready.
  - s_tready = (level<DEPTH) && !(busy && loop_mode) && !flush.
- FSM states: IDLE, SHIFT.
- IDLE:
  - start && level>0 -> SHIFT.
  - The word at rd_ptr is loaded into the shift register.
  - The start cycle is t; first bit_out/bit_val appear at t+1.
  - start with level==0 is ignored; no underrun is raised.
- SHIFT:
  - sps_cnt counts 0..SPS-1; bit_cnt counts 0..DATA_W-1.
  - bit_out changes only when sps_cnt wraps; bit_val=1 when sps_cnt==0.
  - Each bit is held exactly SPS cycles.
- Word boundary (last cycle of the last bit):
  - Stream mode: pop the current word (rd_ptr++, level--). If the remaining level>0 and stop has not been latched, load the next word and keep SPS cadence with no gap.
  - Stream mode, remaining level==0: pulse underrun, go IDLE.
  - Loop mode: rd_ptr advances modulo the captured count (level at start); words are never popped and level stays constant.
  - Stop latched in either mode: go IDLE, no underrun.
- Stop handling:
  - stop is latched on any cycle in SHIFT and cleared on IDLE entry.
  - The word in progress always completes.
- Same-cycle pop and write: level unchanged.
- In IDLE, bit_out holds its last value and bit_val=0.
- flush in IDLE: rd_ptr=wr_ptr=level=0 next cycle. flush in SHIFT is ignored.
- Reset mid-operation: returns every state and output to its reset values in the next cycle; the buffer is emptied.
- loop_en changes while busy have no effect.
- Pointers: $clog2(DEPTH) bits, wrap naturally.

Optional Feature:
MSK_BIT_SRC_PRBS_EN.
- Defined:
  - Adds input prbs_sel (1 bit, sampled on start).
  - With prbs_sel=1, bits come from a PRBS-9 Fibonacci LFSR (x^9+x^5+1), seed 9'h1FF.
  - Output bit = s[8]; feedback = s[8]^s[4]. The LFSR advances once per bit.
  - In PRBS mode, start needs no buffered data, the buffer is untouched, and underrun never fires. stop ends at the next bit boundary.
  - The LFSR reseeds to 9'h1FF on every start.
- Undefined: the port is absent and the bit source is buffer only.

Test Plan:
1. Assert reset for 3 cycles -> bit_out=0, bit_val=0, busy=0, underrun=0, level=0, s_tready=1.
2. Write 8'h90, 8'h10, then pulse start at t -> 16 bits 1001000000010000; bit_val at t+1+20k for k=0..15; underrun pulse at t+320; busy low from t+321.
3. Write 33 words back-to-back -> level=32 and s_tready=0 after the 32nd; the 33rd is not accepted. Flush in IDLE -> level=0, s_tready=1.
4. Load 8'hAA, 8'h55, set loop_en=1, start -> 48 bits of 10101010 01010101 repeating; level stays 2; s_tready=0. Pulse stop mid-word -> that word completes, then IDLE with no underrun.
5. Stream 3 words and assert reset during bit 5 of word 2 -> all outputs reach reset values in the next cycle, level=0. A new write plus start transmits correctly.
6. With MSK_BIT_SRC_PRBS_EN defined: prbs_sel=1, start -> bits 0-8 are 1, bit 9 is 0; the sequence repeats every 511 bits; level unchanged.

Source files
------------

// File: rtl/msk_bit_source.sv
// Serial bit source for msk_mod: buffers DATA_W-bit words and shifts them out at SPS clocks per bit.
// Optional macro MSK_BIT_SRC_PRBS_EN adds a PRBS-9 bit source selected by prbs_sel at start.
module msk_bit_source #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 32,
  parameter int SPS       = 20,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          s_tdata,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop_en,
  input  logic                       flush,
`ifdef MSK_BIT_SRC_PRBS_EN
  input  logic                       prbs_sel,
`endif
  output logic                       bit_out,
  output logic                       bit_val,
  output logic                       busy,
  output logic                       underrun,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(SPS);
  localparam int BW = $clog2(DATA_W);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Stream handshake: a word moves when s_tvalid && s_tready on a rising clk edge;
  // s_tvalid may be held or dropped freely, s_tready never depends on s_tvalid.

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [0:0]        state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, base_q, base_d;
  logic [LW-1:0]     level_q, level_d, loop_cnt_q, loop_cnt_d, loop_off_q, loop_off_d;
  logic              loop_mode_q, loop_mode_d, stop_q, stop_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [CW-1:0]     sps_q, sps_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              bit_out_q, bit_out_d, bit_val_q, bit_val_d;
`ifdef MSK_BIT_SRC_PRBS_EN
  logic              prbs_mode_q, prbs_mode_d;
  logic [8:0]        lfsr_q, lfsr_d;
`endif

  logic              wr_fire, pop, flush_c, underrun_c, load;
  logic              sps_last, bit_last, loop_wrap;
  logic [PW-1:0]     load_addr, loop_addr;
  logic [LW-1:0]     nxt_off;
  logic [BW-1:0]     bit_nxt, sel_nxt;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  assign s_tready = (level_q < LW'(DEPTH)) && !((state_q == ST_SHIFT) && loop_mode_q) && !flush;
  assign wr_fire  = s_tvalid && s_tready;

  assign sps_last  = (sps_q == CW'(SPS-1));
  assign bit_last  = (bit_q == BW'(DATA_W-1));
  assign bit_nxt   = bit_q + BW'(1);
  assign sel_nxt   = (MSB_FIRST != 0) ? (BW'(DATA_W-1) - bit_nxt) : bit_nxt;
  // Loop replay walks base..base+count-1 without consuming the words.
  assign nxt_off   = loop_off_q + LW'(1);
  assign loop_wrap = (nxt_off == loop_cnt_q);
  assign loop_addr = loop_wrap ? base_q : rd_ptr_q + PW'(1);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    base_d      = base_q;
    level_d     = level_q;
    loop_mode_d = loop_mode_q;
    loop_cnt_d  = loop_cnt_q;
    loop_off_d  = loop_off_q;
    stop_d      = stop_q;
    word_d      = word_q;
    sps_d       = sps_q;
    bit_d       = bit_q;
    bit_out_d   = bit_out_q;
    bit_val_d   = 1'b0;
    pop         = 1'b0;
    flush_c     = 1'b0;
    underrun_c  = 1'b0;
    load        = 1'b0;
    load_addr   = rd_ptr_q;
`ifdef MSK_BIT_SRC_PRBS_EN
    prbs_mode_d = prbs_mode_q;
    lfsr_d      = lfsr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (flush) begin
          flush_c = 1'b1;
        end else if (start) begin
`ifdef MSK_BIT_SRC_PRBS_EN
          if (prbs_sel) begin
            state_d     = ST_SHIFT;
            prbs_mode_d = 1'b1;
            lfsr_d      = {8'hFF, 1'b0};
            bit_out_d   = 1'b1;
            bit_val_d   = 1'b1;
            sps_d       = '0;
          end else
`endif
          if (level_q != '0) begin
            state_d     = ST_SHIFT;
            loop_mode_d = loop_en;
            loop_cnt_d  = level_q;
            loop_off_d  = '0;
            base_d      = rd_ptr_q;
            load        = 1'b1;
`ifdef MSK_BIT_SRC_PRBS_EN
            prbs_mode_d = 1'b0;
`endif
          end
        end
      end
      default: begin
        stop_d = stop_q | stop;
        if (!sps_last) begin
          sps_d = sps_q + CW'(1);
        end else begin
          sps_d = '0;
`ifdef MSK_BIT_SRC_PRBS_EN
          if (prbs_mode_q) begin
            if (stop_q) begin
              state_d = ST_IDLE;
            end else begin
              bit_out_d = lfsr_q[8];
              bit_val_d = 1'b1;
              lfsr_d    = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
            end
          end else
`endif
          if (!bit_last) begin
            bit_d     = bit_nxt;
            bit_out_d = word_q[sel_nxt];
            bit_val_d = 1'b1;
          end else if (loop_mode_q) begin
            if (stop_q) begin
              state_d  = ST_IDLE;
              rd_ptr_d = base_q;
            end else begin
              rd_ptr_d   = loop_addr;
              loop_off_d = loop_wrap ? '0 : nxt_off;
              load       = 1'b1;
              load_addr  = loop_addr;
            end
          end else begin
            pop      = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (stop_q) begin
              state_d = ST_IDLE;
            end else if (level_q > LW'(1)) begin
              load      = 1'b1;
              load_addr = rd_ptr_q + PW'(1);
            end else begin
              underrun_c = 1'b1;
              state_d    = ST_IDLE;
            end
          end
        end
      end
    endcase
    if (load) begin
      word_d    = mem_q[load_addr];
      bit_out_d = first_bit(word_d);
      bit_val_d = 1'b1;
      sps_d     = '0;
      bit_d     = '0;
    end
    if (flush_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(wr_fire);
      level_d  = level_q + LW'(wr_fire) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= s_tdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      base_q      <= '0;
      level_q     <= '0;
      loop_mode_q <= 1'b0;
      loop_cnt_q  <= '0;
      loop_off_q  <= '0;
      stop_q      <= 1'b0;
      word_q      <= '0;
      sps_q       <= '0;
      bit_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_val_q   <= 1'b0;
`ifdef MSK_BIT_SRC_PRBS_EN
      prbs_mode_q <= 1'b0;
      lfsr_q      <= 9'h1FF;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      base_q      <= base_d;
      level_q     <= level_d;
      loop_mode_q <= loop_mode_d;
      loop_cnt_q  <= loop_cnt_d;
      loop_off_q  <= loop_off_d;
      stop_q      <= stop_d;
      word_q      <= word_d;
      sps_q       <= sps_d;
      bit_q       <= bit_d;
      bit_out_q   <= bit_out_d;
      bit_val_q   <= bit_val_d;
`ifdef MSK_BIT_SRC_PRBS_EN
      prbs_mode_q <= prbs_mode_d;
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign bit_out  = bit_out_q;
  assign bit_val  = bit_val_q;
  assign busy     = (state_q == ST_SHIFT);
  assign underrun = underrun_c;
  assign level    = level_q;

endmodule

// File: tb/tb_msk_bit_source.sv
// Self-checking bench for msk_bit_source: table-driven streams, buffer fill/flush, loop replay,
// mid-operation reset and (with MSK_BIT_SRC_PRBS_EN) the PRBS-9 source.
module tb_msk_bit_source;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int SPS    = 20;
  localparam int LW     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid, s_tready;
  logic              start, stop, loop_en, flush;
  logic              bit_out, bit_val, busy, underrun;
  logic [LW-1:0]     level;
`ifdef MSK_BIT_SRC_PRBS_EN
  logic              prbs_sel;
`endif

  msk_bit_source #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SPS(SPS), .MSB_FIRST(1)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .start(start), .stop(stop), .loop_en(loop_en), .flush(flush),
`ifdef MSK_BIT_SRC_PRBS_EN
    .prbs_sel(prbs_sel),
`endif
    .bit_out(bit_out), .bit_val(bit_val), .busy(busy), .underrun(underrun), .level(level)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int und_cnt  = 0;
  int und_cyc  = -1;

  // scoreboard: expected bit values and the cycle their bit_val pulse must appear
  logic [0:0] exp_q[$];
  int         exp_t_q[$];

  typedef struct {
    int          n;
    logic [23:0] words;
    logic [23:0] bits;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    logic [0:0] eb;
    int et;
    if (underrun) begin
      und_cnt++;
      und_cyc = cyc;
    end
    if (bit_val) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bit_val", 1, 0);
      end else begin
        eb = exp_q.pop_front();
        et = exp_t_q.pop_front();
        chk("bit_out", {31'd0, bit_out}, {31'd0, eb});
        chk("bit_val_cycle", cyc, et);
      end
    end
  end

  // driver tasks
  task automatic try_write(input logic [7:0] d, output logic acc);
    @(posedge clk); #1;
    s_tdata  = d;
    s_tvalid = 1'b1;
    @(negedge clk);
    acc = s_tready;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] d);
    logic acc;
    try_write(d, acc);
    chk("write_accept", {31'd0, acc}, 1);
  endtask

  task automatic pulse_start(output int t_first);
    @(posedge clk); #1;
    start   = 1'b1;
    t_first = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] w, input int t0, input int idx0);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(w[7-k]);
      exp_t_q.push_back(t0 + SPS * (idx0 + k));
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output int t_idle);
    t_idle = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        t_idle = cyc;
        break;
      end
    end
    if (t_idle < 0) chk("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_bit_out"},  {31'd0, bit_out},  0);
    chk({tag, "_bit_val"},  {31'd0, bit_val},  0);
    chk({tag, "_busy"},     {31'd0, busy},     0);
    chk({tag, "_underrun"}, {31'd0, underrun}, 0);
    chk({tag, "_level"},    32'(level),        0);
    chk({tag, "_s_tready"}, {31'd0, s_tready}, 1);
  endtask

  task automatic stream_run(input vec_t v);
    int tf, ti, u0;
    int nb;
    logic [7:0] w;
    nb = v.n * 8;
    for (int i = 0; i < v.n; i++) begin
      w = v.words[23 - 8*i -: 8];
      write_word(w);
    end
    u0 = und_cnt;
    pulse_start(tf);
    for (int k = 0; k < nb; k++) begin
      exp_q.push_back(v.bits[23-k]);
      exp_t_q.push_back(tf + SPS * k);
    end
    wait_idle(nb * SPS + 100, ti);
    chk("underrun_count",  und_cnt - u0, 1);
    chk("underrun_cycle",  und_cyc, tf + nb * SPS - 1);
    chk("busy_low_cycle",  ti, tf + nb * SPS);
    chk("stream_bits_left", exp_q.size(), 0);
    chk("stream_level",    32'(level), 0);
  endtask

  initial begin
    int tf, ti, u0, n_acc;
    logic acc;
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int tf, ti, u0, n_acc;
    logic acc;
    vecs[0] = '{2, 24'h901000, 24'b1001000000010000_00000000};
    vecs[1] = '{2, 24'hA53C00, 24'b1010010100111100_00000000};
    vecs[2] = '{3, 24'hFF0081, 24'b11111111_00000000_10000001};
    vecs[3] = '{1, 24'h010000, 24'b00000001_00000000_00000000};

    reset = 1'b1; s_tdata = '0; s_tvalid = 1'b0; start = 1'b0; stop = 1'b0;
    loop_en = 1'b0; flush = 1'b0;
`ifdef MSK_BIT_SRC_PRBS_EN
    prbs_sel = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // stream mode with underrun at the end of the data
    for (int i = 0; i < 4; i++) stream_run(vecs[i]);

    // start on an empty buffer is ignored and raises nothing
    u0 = und_cnt;
    pulse_start(tf);
    repeat (5) @(negedge clk);
    chk("empty_start_busy", {31'd0, busy}, 0);
    chk("empty_start_underrun", und_cnt - u0, 0);

    // fill past capacity, then flush
    n_acc = 0;
    for (int i = 0; i < 33; i++) begin
      try_write(8'(i), acc);
      if (acc) n_acc++;
      if (i == 32) chk("accept_33rd", {31'd0, acc}, 0);
    end
    chk("accepted_count", n_acc, 32);
    @(negedge clk);
    chk("full_level", 32'(level), 32);
    chk("full_s_tready", {31'd0, s_tready}, 0);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_s_tready_low", {31'd0, s_tready}, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_level", 32'(level), 0);
    chk("flush_s_tready", {31'd0, s_tready}, 1);

    // loop replay of AA 55, stopped in the middle of the sixth word
    write_word(8'hAA);
    write_word(8'h55);
    loop_en = 1'b1;
    u0 = und_cnt;
    pulse_start(tf);
    loop_en = 1'b0;
    for (int r = 0; r < 3; r++) begin
      push_word(8'hAA, tf, 16*r);
      push_word(8'h55, tf, 16*r + 8);
    end
    wait_cyc(tf + SPS * 20);
    chk("loop_level", 32'(level), 2);
    chk("loop_s_tready", {31'd0, s_tready}, 0);
    chk("loop_busy", {31'd0, busy}, 1);
    wait_cyc(tf + SPS * 43 + 5);
    pulse_stop();
    wait_idle(2000, ti);
    chk("loop_busy_low_cycle", ti, tf + 48 * SPS);
    chk("loop_no_underrun", und_cnt - u0, 0);
    chk("loop_bits_left", exp_q.size(), 0);
    chk("loop_level_after", 32'(level), 2);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;

    // reset during bit 5 of the second word
    write_word(8'hC3);
    write_word(8'h5A);
    write_word(8'h0F);
    u0 = und_cnt;
    pulse_start(tf);
    push_word(8'hC3, tf, 0);
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(1'(8'h5A >> (7 - k)));
      exp_t_q.push_back(tf + SPS * (8 + k));
    end
    wait_cyc(tf + SPS * 13 + 3);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals("midreset");
    chk("midreset_bits_left", exp_q.size(), 0);
    chk("midreset_no_underrun", und_cnt - u0, 0);
    stream_run('{1, 24'h6B0000, 24'b01101011_00000000_00000000});

`ifdef MSK_BIT_SRC_PRBS_EN
    begin
      logic [8:0] s;
      int lvl0;
      write_word(8'h3C);
      @(negedge clk);
      lvl0 = 32'(level);
      prbs_sel = 1'b1;
      u0 = und_cnt;
      pulse_start(tf);
      prbs_sel = 1'b0;
      s = 9'h1FF;
      for (int k = 0; k < 1022; k++) begin
        exp_q.push_back(s[8]);
        exp_t_q.push_back(tf + SPS * k);
        s = {s[7:0], s[8] ^ s[4]};
      end
      wait_cyc(tf + SPS * 1022 - 10);
      chk("prbs_level", 32'(level), 32'(lvl0));
      pulse_stop();
      wait_idle(200, ti);
      chk("prbs_busy_low_cycle", ti, tf + SPS * 1022);
      chk("prbs_no_underrun", und_cnt - u0, 0);
      chk("prbs_bits_left", exp_q.size(), 0);
    end
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
